cfs_md_rx_packer: RTL and testbench
===================================

// Module: cfs_md_rx_packer
// PURPOSE
//  Upstream MD master for the aligner RX port: packs an 8-bit byte stream into MD beats (data/offset/size).
//  A packet starts at a configurable byte lane. Beats are emitted when a word fills or at packet end.
//  Counts beats rejected with md_err. Sits between a byte-oriented source and the aligner md_rx_* pins.
// PARAMETERS
//  ALGN_DATA_WIDTH  32  MD data width in bits; power of two, >= 8
//  CNT_ERR_WIDTH    8   width of saturating error counter
//  MAX_RETRY        3   re-sends per errored beat; used only with CFS_MD_RX_PACKER_RETRY_EN
//  (derived) OFFSET_W = max(1, clog2(DW/8)), SIZE_W = clog2(DW/8)+1, NB = DW/8
// PORTS
//  clk          in   1         clock (single domain)
//  reset_n      in   1         async active-low reset
//  cfg_offset   in   OFFSET_W  start lane of next packet; sampled on its first accepted byte
//  in_valid     in   1         byte stream valid
//  in_data      in   8         byte
//  in_last      in   1         marks last byte of packet
//  in_ready     out  1         byte accepted when in_valid & in_ready
//  md_valid     out  1         MD beat valid
//  md_data      out  DW        beat data; unused lanes zero
//  md_offset    out  OFFSET_W  first valid lane
//  md_size      out  SIZE_W    number of valid bytes, 1..NB
//  md_ready     in   1         MD handshake completes on md_valid & md_ready
//  md_err       in   1         sampled with md_ready; 1 = beat rejected
//  clr_cnt_err  in   1         synchronous clear of cnt_err
//  cnt_err      out  CNT_W     saturating count of errored handshakes
// BEHAVIOUR
//  Interface: one clock clk; asynchronous active-low reset reset_n.
//  Reset: all outputs 0, in_ready 0 during reset and 1 the first cycle after. State is FILL, lane ptr 0, first-flag set.
//  FSM FILL: in_ready=1. Accepted byte is written to lane ptr (ptr=cfg_offset on first byte of packet).
//   Beat closes when ptr==NB-1 or in_last; then -> SEND.
//   Next lane ptr: 0 after a closed beat. First-flag set after in_last.
//  FSM SEND: in_ready=0. md_valid=1; data/offset/size held stable until handshake.
//   Beat appears on md_* the cycle after its closing byte is accepted. Latency 1.
//   Handshake with md_err=0 -> FILL, clear beat register.
//   Handshake with md_err=1 -> cnt_err+1 (saturates at all-ones, no wrap); see CONFIGURATION.
//  md_offset = start lane of the beat; md_size = (last lane - offset + 1). offset+size <= NB always.
//  Boundaries:
//   - in_last on a byte at lane NB-1 closes one full beat; no empty beat follows.
//   - in_last on the first byte at offset k gives size 1, offset k.
//   - cfg_offset changes mid-packet are ignored.
//   - clr_cnt_err and error handshake in the same cycle: clear wins, cnt_err=0.
//   - md_ready while md_valid=0 has no effect.
//   - Async reset mid-SEND: md_valid drops immediately. The partial beat and packet are discarded.
// CONFIGURATION
//  `CFS_MD_RX_PACKER_RETRY_EN` defined:
//   - An errored beat stays in SEND and is re-presented unchanged next cycle, up to MAX_RETRY re-sends.
//   - If still errored after MAX_RETRY re-sends, the beat is dropped and the FSM returns to FILL.
//   - Every errored handshake increments cnt_err.
//  Undefined: an errored beat is dropped after a single handshake (-> FILL). MAX_RETRY is unused.
// STRUCTURE
//  cfs_algn_pkg holds:
//   - OFFSET_W/SIZE_W width functions
//   - FSM state enum {FILL, SEND}
//   - STATUS_CNT_DROP_WIDTH-style width constants
//  Sub-module cfs_sat_counter (width param, inc, clr, clr-priority) implements cnt_err.
//  Packer datapath and FSM stay in this module.
// TESTING (DW=32)
//  - Bytes 11,22,33,44 (last on 44), cfg_offset=0 -> one beat data=0x44332211, offset 0, size 4.
//  - cfg_offset=2, bytes AA,BB,CC (last on CC):
//     beat 1 = data 0xBBAA0000, offset 2, size 2
//     beat 2 = data 0x000000CC, offset 0, size 1
//  - md_ready held low 10 cycles in SEND -> md_* stable, in_ready=0 throughout; beat accepted on ready.
//  - md_err=1 on 300 handshakes -> cnt_err saturates at 255; clr_cnt_err with simultaneous err -> 0.
//  - RETRY_EN, MAX_RETRY=3, md_err always 1 -> 4 handshakes of identical beat, cnt_err=4, then FILL.
//  - Without RETRY_EN, same stimulus -> 1 handshake, then FILL.
//  - Assert reset_n during SEND -> md_valid=0 same cycle; after release first beat starts at cfg_offset.

Source files
------------

// File: rtl/cfs_md_rx_packer_pkg.sv
// Shared types and width helpers for the MD RX byte packer.
//   state_e   : packer FSM states (FILL collects bytes, SEND presents a beat)
//   BYTE_W    : width of one byte lane / of the input byte stream
//   offset_w(): lane-index width, max(1, clog2(DW/8))
//   size_w()  : beat byte-count width, clog2(DW/8)+1
//   retry_w() : width of a counter that must reach n
package cfs_md_rx_packer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int unsigned offset_w(input int unsigned dw);
    return (dw / BYTE_W > 1) ? $clog2(dw / BYTE_W) : 1;
  endfunction

  function automatic int unsigned size_w(input int unsigned dw);
    return $clog2(dw / BYTE_W) + 1;
  endfunction

  function automatic int unsigned retry_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cfs_md_rx_packer_if.sv
// Byte-stream input and MD beat output of the packer, bundled as one interface.
//   in_valid/in_data/in_last/in_ready : byte source handshake
//   md_valid/md_data/md_offset/md_size: MD beat towards the aligner
//   md_ready/md_err                   : aligner response
// Modports: master = packer side (drives MD beats), slave = byte source / aligner side.
interface cfs_md_rx_packer_if #(
  parameter int unsigned DW = 32
) ();
  import cfs_md_rx_packer_pkg::*;

  localparam int unsigned OFFSET_W = offset_w(DW);
  localparam int unsigned SIZE_W   = size_w(DW);

  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_last;
  logic                in_ready;
  logic                md_valid;
  logic [DW-1:0]       md_data;
  logic [OFFSET_W-1:0] md_offset;
  logic [SIZE_W-1:0]   md_size;
  logic                md_ready;
  logic                md_err;

  modport master (
    input  in_valid, in_data, in_last, md_ready, md_err,
    output in_ready, md_valid, md_data, md_offset, md_size
  );

  modport slave (
    output in_valid, in_data, in_last, md_ready, md_err,
    input  in_ready, md_valid, md_data, md_offset, md_size
  );

endinterface

// File: rtl/cfs_md_rx_packer_sat_counter.sv
// cfs_sat_counter: saturating up-counter, synchronous clear has priority over increment.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event
//   clr        : clear to zero (wins over inc)
//   cnt        : registered count, sticks at all-ones
module cfs_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cfs_md_rx_packer.sv
// cfs_md_rx_packer: packs an 8-bit byte stream into MD beats (data/offset/size).
// A packet starts at lane cfg_offset; a beat closes when its top lane fills or on
// in_last, and is presented on md_* the next cycle until md_ready.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   cfg_offset   : start lane of next packet, sampled on its first accepted byte
//   clr_cnt_err  : synchronous clear of cnt_err
//   cnt_err      : saturating count of handshakes with md_err=1
//   bus          : byte stream in / MD beat out (cfs_md_rx_packer_if.master)
// Optional feature: define CFS_MD_RX_PACKER_RETRY_EN to re-present an errored beat
// up to MAX_RETRY times before dropping it; otherwise it is dropped after one try.
module cfs_md_rx_packer
  import cfs_md_rx_packer_pkg::*;
#(
  parameter int unsigned ALGN_DATA_WIDTH = 32,
  parameter int unsigned CNT_ERR_WIDTH   = 8,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [offset_w(ALGN_DATA_WIDTH)-1:0]  cfg_offset,
  input  logic                                  clr_cnt_err,
  output logic [CNT_ERR_WIDTH-1:0]              cnt_err,
  cfs_md_rx_packer_if.master                    bus
);

  localparam int unsigned NB       = ALGN_DATA_WIDTH / BYTE_W;
  localparam int unsigned OFFSET_W = offset_w(ALGN_DATA_WIDTH);
  localparam int unsigned SIZE_W   = size_w(ALGN_DATA_WIDTH);
  localparam int unsigned RETRY_W  = retry_w(MAX_RETRY);
`ifdef CFS_MD_RX_PACKER_RETRY_EN
  localparam int unsigned RETRY_LIM = MAX_RETRY;
`else
  localparam int unsigned RETRY_LIM = 0;
`endif

  state_e              state;
  logic [OFFSET_W-1:0] ptr;
  logic [OFFSET_W-1:0] beat_off;
  logic                first;
  logic [RETRY_W-1:0]  retry_cnt;

  logic [OFFSET_W-1:0] lane_c;
  logic [OFFSET_W-1:0] start_c;
  logic                accept_c;
  logic                close_c;
  logic                hs_c;
  logic                retire_c;

  // The first byte of a packet goes to cfg_offset; later beats of it start at lane 0.
  assign accept_c = bus.in_valid & bus.in_ready;
  assign lane_c   = first ? cfg_offset : ptr;
  assign start_c  = first ? cfg_offset : beat_off;
  assign close_c  = bus.in_last | (lane_c == OFFSET_W'(NB - 1));
  assign hs_c     = bus.md_valid & bus.md_ready;
  // A beat leaves SEND when accepted, or when its error retries are used up.
  assign retire_c = ~bus.md_err | (retry_cnt == RETRY_W'(RETRY_LIM));

  // Packer FSM and beat register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FILL;
      ptr           <= '0;
      beat_off      <= '0;
      first         <= 1'b1;
      retry_cnt     <= '0;
      bus.in_ready  <= 1'b0;
      bus.md_valid  <= 1'b0;
      bus.md_data   <= '0;
      bus.md_offset <= '0;
      bus.md_size   <= '0;
    end else begin
      case (state)
        FILL: begin
          bus.in_ready <= 1'b1;
          if (accept_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
              if (lane_c == OFFSET_W'(i)) begin
                bus.md_data[BYTE_W*i +: BYTE_W] <= bus.in_data;
              end
            end
            bus.md_offset <= start_c;
            bus.md_size   <= SIZE_W'(lane_c) - SIZE_W'(start_c) + SIZE_W'(1);
            if (close_c) begin
              state        <= SEND;
              bus.in_ready <= 1'b0;
              bus.md_valid <= 1'b1;
              ptr          <= '0;
              beat_off     <= '0;
              first        <= bus.in_last;
            end else begin
              ptr      <= lane_c + OFFSET_W'(1);
              beat_off <= start_c;
              first    <= 1'b0;
            end
          end
        end
        SEND: begin
          if (hs_c) begin
            if (retire_c) begin
              state         <= FILL;
              bus.in_ready  <= 1'b1;
              bus.md_valid  <= 1'b0;
              bus.md_data   <= '0;
              bus.md_offset <= '0;
              bus.md_size   <= '0;
              retry_cnt     <= '0;
            end else begin
              retry_cnt <= retry_cnt + RETRY_W'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Error handshake counter; clear beats a simultaneous error.
  cfs_sat_counter #(
    .W (CNT_ERR_WIDTH)
  ) u_cnt_err (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (hs_c & bus.md_err),
    .clr   (clr_cnt_err),
    .cnt   (cnt_err)
  );

endmodule

// File: tb/tb_cfs_md_rx_packer.sv
// Bench for cfs_md_rx_packer (DW=32): a packet-level model splits each packet into
// expected beats; a negedge process compares every valid beat and cnt_err.
module tb_cfs_md_rx_packer;

  localparam int unsigned DW        = 32;
  localparam int unsigned NB        = 4;
  localparam int unsigned OW        = 2;
  localparam int unsigned CW        = 8;
  localparam int unsigned MAX_RETRY = 3;
`ifdef CFS_MD_RX_PACKER_RETRY_EN
  localparam int unsigned SENDS = 4;
`else
  localparam int unsigned SENDS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [OW-1:0] cfg_offset;
  logic          clr_cnt_err;
  logic [CW-1:0] cnt_err;

  cfs_md_rx_packer_if #(.DW(DW)) bus ();

  cfs_md_rx_packer #(
    .ALGN_DATA_WIDTH (DW),
    .CNT_ERR_WIDTH   (CW),
    .MAX_RETRY       (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_offset  (cfg_offset),
    .clr_cnt_err (clr_cnt_err),
    .cnt_err     (cnt_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   off;
    int unsigned   size;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned cnt_exp;
  int unsigned beat_hs;
  int unsigned err_hs_total;
  int unsigned errs_this_beat;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet -> beats: first beat holds min(n, NB-off) bytes from lane off, then full words, then remainder.
  function automatic void model_push(input int unsigned off, input logic [63:0] pkt, input int unsigned n);
    int unsigned pos;
    int unsigned start;
    int unsigned take;
    beat_t       b;
    pos   = 0;
    start = off;
    while (pos < n) begin
      take   = ((n - pos) < (NB - start)) ? (n - pos) : (NB - start);
      b.data = '0;
      for (int unsigned j = 0; j < take; j++) b.data[8*(start+j) +: 8] = pkt[8*(pos+j) +: 8];
      b.off  = start;
      b.size = take;
      exp_q.push_back(b);
      pos   += take;
      start  = 0;
    end
  endfunction

  // Handshake and error-counter model, evaluated on pre-edge values.
  always @(posedge clk) begin
    if (reset_n) begin
      if (clr_cnt_err) cnt_exp = 0;
      else if (bus.md_valid && bus.md_ready && bus.md_err && cnt_exp < 255) cnt_exp++;
      if (bus.md_valid && bus.md_ready) begin
        beat_hs++;
        if (bus.md_err) begin
          err_hs_total++;
          errs_this_beat++;
        end
        if (!bus.md_err || errs_this_beat == SENDS) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          errs_this_beat = 0;
        end
      end
    end
  end

  // Compare process.
  always @(negedge clk) begin
    if (reset_n) begin
      check("cnt_err", 64'(cnt_err), 64'(cnt_exp));
      if (bus.md_valid) begin
        check("in_ready_in_send", 64'(bus.in_ready), 64'(0));
        check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          check("md_data", 64'(bus.md_data), 64'(exp_q[0].data));
          check("md_offset", 64'(bus.md_offset), 64'(exp_q[0].off));
          check("md_size", 64'(bus.md_size), 64'(exp_q[0].size));
        end
      end
    end
  end

  task automatic send_pkt(input int unsigned off, input logic [63:0] pkt, input int unsigned n,
                          input bit wiggle);
    int unsigned c;
    bit          ok;
    model_push(off, pkt, n);
    cfg_offset = OW'(off);
    for (int unsigned i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pkt[8*i +: 8];
      bus.in_last  = (i == n - 1);
      c  = 0;
      ok = 1'b0;
      while (!ok && c < 50) begin
        @(posedge clk);
        ok = bus.in_ready;
        c++;
      end
      check("byte_accepted", 64'(ok), 64'(1));
      #1;
      if (wiggle && i == 0) cfg_offset = OW'(0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    reset_n        = 1'b0;
    cfg_offset     = '0;
    clr_cnt_err    = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.md_ready   = 1'b0;
    bus.md_err     = 1'b0;
    cnt_exp        = 0;
    beat_hs        = 0;
    err_hs_total   = 0;
    errs_this_beat = 0;

    // Reset values.
    #12;
    check("rst_md_valid", 64'(bus.md_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_md_data", 64'(bus.md_data), 64'(0));
    check("rst_cnt_err", 64'(cnt_err), 64'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_reset", 64'(bus.in_ready), 64'(1));

    // Full word at offset 0, beat visible one cycle after the closing byte.
    bus.md_ready = 1'b1;
    send_pkt(0, 64'h44332211, 4, 1'b0);
    @(negedge clk);
    check("full_valid", 64'(bus.md_valid), 64'(1));
    check("full_data", 64'(bus.md_data), 64'h44332211);
    check("full_offset", 64'(bus.md_offset), 64'(0));
    check("full_size", 64'(bus.md_size), 64'(4));

    // Offset 2, three bytes, cfg_offset changed mid-packet: BBAA0000/2/2 then 000000CC/0/1.
    send_pkt(2, 64'hCCBBAA, 3, 1'b1);
    @(negedge clk);
    check("tail_data", 64'(bus.md_data), 64'h000000CC);
    check("tail_offset", 64'(bus.md_offset), 64'(0));
    check("tail_size", 64'(bus.md_size), 64'(1));

    // Single-byte packet at the top lane.
    send_pkt(3, 64'hDD, 1, 1'b0);
    @(negedge clk);
    check("one_data", 64'(bus.md_data), 64'hDD000000);
    check("one_offset", 64'(bus.md_offset), 64'(3));
    check("one_size", 64'(bus.md_size), 64'(1));

    // Two full words; last byte on lane NB-1 must not create an empty beat.
    send_pkt(0, 64'h8877665544332211, 8, 1'b0);
    wait_drain();

    // Backpressure: beat held for 10 cycles.
    bus.md_ready = 1'b0;
    send_pkt(1, 64'h030201, 3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.md_valid), 64'(1));
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
      check("stall_data", 64'(bus.md_data), 64'h03020100);
    end
    bus.md_ready = 1'b1;
    @(negedge clk);
    check("stall_released", 64'(bus.md_valid), 64'(0));

    // Error counter saturation.
    bus.md_err = 1'b1;
    while (err_hs_total < 300) send_pkt(0, 64'(err_hs_total & 255), 1, 1'b0);
    wait_drain();
    @(negedge clk);
    check("cnt_saturated", 64'(cnt_err), 64'(255));

    // Clear coincident with an errored handshake.
    send_pkt(0, 64'h5A, 1, 1'b0);
    clr_cnt_err = 1'b1;
    @(posedge clk); #1 clr_cnt_err = 1'b0;
    @(negedge clk);
    check("clr_wins", 64'(cnt_err), 64'(0));
    wait_drain();

    // Persistent error: number of handshakes per beat.
    clr_cnt_err = 1'b1;
    @(posedge clk); #1 clr_cnt_err = 1'b0;
    @(negedge clk);
    beat_hs = 0;
    send_pkt(1, 64'hE1, 1, 1'b0);
    wait_drain();
    check("err_handshakes", 64'(beat_hs), 64'(SENDS));
    check("err_cnt", 64'(cnt_err), 64'(SENDS));
    check("err_back_to_fill", 64'(bus.in_ready), 64'(1));

    // Asynchronous reset while a beat is pending.
    bus.md_err   = 1'b0;
    bus.md_ready = 1'b0;
    send_pkt(2, 64'h6655, 2, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", 64'(bus.md_valid), 64'(1));
    #1 reset_n = 1'b0;
    exp_q.delete();
    errs_this_beat = 0;
    cnt_exp        = 0;
    #1;
    check("reset_drops_valid", 64'(bus.md_valid), 64'(0));
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    bus.md_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    send_pkt(3, 64'h77, 1, 1'b0);
    @(negedge clk);
    check("post_reset_data", 64'(bus.md_data), 64'h77000000);
    check("post_reset_offset", 64'(bus.md_offset), 64'(3));
    check("post_reset_size", 64'(bus.md_size), 64'(1));
    wait_drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
